risc_prog_loader: RTL and testbench



---
 rtl/risc_loader_pkg.sv | 29 ++
 rtl/risc_loader_hdr_decode.sv | 25 ++
 rtl/risc_prog_loader.sv | 146 ++++++++++++++
 tb/tb_risc_prog_loader.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_loader_pkg
// Description : Header field layout, state encodings and memory-select codes
//               shared by the RISCV_32 program loader.
// Revision    : 1.0
// ============================================================================
package risc_loader_pkg;

    localparam int c_hdr_go_bit   = 31;
    localparam int c_hdr_tgt_bit  = 30;
    localparam int c_hdr_cnt_lsb  = 16;
    localparam int c_hdr_cnt_w    = 10;
    localparam int c_hdr_base_lsb = 0;
    localparam int c_hdr_base_w   = 10;

    // Bits [29:26] and [15:10] are reserved and must be zero.
    localparam logic [31:0] c_hdr_rsvd_mask = 32'h3C00_FC00;

    localparam logic [1:0] c_st_hdr   = 2'd0;
    localparam logic [1:0] c_st_data  = 2'd1;
    localparam logic [1:0] c_st_start = 2'd2;
    localparam logic [1:0] c_st_run   = 2'd3;

    localparam logic c_mem_imem = 1'b0;
    localparam logic c_mem_dmem = 1'b1;

endpackage : risc_loader_pkg
`default_nettype wire

// File: rtl/risc_loader_hdr_decode.sv
`default_nettype none
// ============================================================================
// Module      : risc_loader_hdr_decode
// Description : Combinational header field extraction and reserved-bit check.
// Revision    : 1.0
// ============================================================================
module risc_loader_hdr_decode
    import risc_loader_pkg::*;
(
    input  logic [31:0]               i_hdr,
    output logic                      o_go,
    output logic                      o_target,
    output logic [c_hdr_cnt_w-1:0]    o_count,
    output logic [c_hdr_base_w-1:0]   o_base,
    output logic                      o_rsvd_err
);

    assign o_go       = i_hdr[c_hdr_go_bit];
    assign o_target   = i_hdr[c_hdr_tgt_bit];
    assign o_count    = i_hdr[c_hdr_cnt_lsb +: c_hdr_cnt_w];
    assign o_base     = i_hdr[c_hdr_base_lsb +: c_hdr_base_w];
    assign o_rsvd_err = |(i_hdr & c_hdr_rsvd_mask);

endmodule : risc_loader_hdr_decode
`default_nettype wire

// File: rtl/risc_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : risc_prog_loader
// Description : Streams headers/payload into the core's IMEM/DMEM, then starts
//               the core at a programmed PC and reclaims memories on HALTED.
// Revision    : 1.0
// ============================================================================
module risc_prog_loader
    import risc_loader_pkg::*;
#(
    parameter int ADDR_W = 10
)
(
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              core_halted,
    output logic              core_start,
    output logic [ADDR_W-1:0] core_pc_init,
    output logic              core_run,
    output logic              busy,
    output logic              err,
    output logic [31:0]       checksum
);

    logic [1:0]              r_state;
    logic                    r_sel;
    logic [ADDR_W-1:0]       r_base;
    logic [c_hdr_cnt_w-1:0]  r_cnt;
    logic [c_hdr_cnt_w-1:0]  r_idx;
    logic                    r_mem_we;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [31:0]             r_mem_wdata;
    logic [ADDR_W-1:0]       r_pc_init;
    logic                    r_err;
    logic [31:0]             r_checksum;

    logic                    w_go;
    logic                    w_target;
    logic [c_hdr_cnt_w-1:0]  w_hdr_count;
    logic [c_hdr_base_w-1:0] w_hdr_base;
    logic                    w_rsvd_err;
    logic                    w_beat;
    logic [ADDR_W:0]         w_addr_sum;
    logic                    w_in_range;
    logic                    w_last;

    risc_loader_hdr_decode u_hdr_decode (
        .i_hdr      (in_data),
        .o_go       (w_go),
        .o_target   (w_target),
        .o_count    (w_hdr_count),
        .o_base     (w_hdr_base),
        .o_rsvd_err (w_rsvd_err)
    );

    assign w_beat     = in_valid & in_ready;
    // One extra bit so an address past the top of memory is detectable.
    assign w_addr_sum = {1'b0, r_base} + (ADDR_W+1)'(r_idx);
    assign w_in_range = ~w_addr_sum[ADDR_W];
    assign w_last     = (r_idx == (r_cnt - 1'b1));

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state     <= c_st_hdr;
            r_sel       <= c_mem_imem;
            r_base      <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_pc_init   <= '0;
            r_err       <= 1'b0;
            r_checksum  <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                c_st_hdr: begin
                    if (w_beat) begin
                        if (w_rsvd_err) begin
                            r_err <= 1'b1;
                        end else if (w_go) begin
                            r_pc_init <= ADDR_W'(w_hdr_base);
                            r_state   <= c_st_start;
                        end else if (w_hdr_count != '0) begin
                            r_sel   <= w_target;
                            r_base  <= ADDR_W'(w_hdr_base);
                            r_cnt   <= w_hdr_count;
                            r_idx   <= '0;
                            r_state <= c_st_data;
                        end
                    end
                end
                c_st_data: begin
                    if (w_beat) begin
                        // Out-of-range words are still consumed to keep framing.
                        r_checksum  <= r_checksum ^ in_data;
                        r_mem_addr  <= w_addr_sum[ADDR_W-1:0];
                        r_mem_wdata <= in_data;
                        if (w_in_range) begin
                            r_mem_we <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_idx <= r_idx + 1'b1;
                        if (w_last) begin
                            r_state <= c_st_hdr;
                        end
                    end
                end
                c_st_start: begin
                    r_state <= c_st_run;
                end
                c_st_run: begin
                    if (core_halted) begin
                        r_state <= c_st_hdr;
                    end
                end
                default: begin
                    r_state <= c_st_hdr;
                end
            endcase
        end
    end

    assign in_ready     = (r_state == c_st_hdr) | (r_state == c_st_data);
    assign busy         = (r_state == c_st_data);
    assign core_start   = (r_state == c_st_start);
    assign core_run     = (r_state == c_st_run);
    assign core_pc_init = r_pc_init;
    assign mem_we       = r_mem_we;
    assign mem_sel      = r_sel;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign err          = r_err;
    assign checksum     = r_checksum;

endmodule : risc_prog_loader
`default_nettype wire

// File: tb/tb_risc_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_risc_prog_loader
// Description : Self-checking bench for risc_prog_loader against a behavioural
//               model of the loader's stream/memory/run behaviour.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_risc_prog_loader;

    localparam int ADDR_W = 10;

    logic              clk1 = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              mem_we;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_halted;
    logic              core_start;
    logic [ADDR_W-1:0] core_pc_init;
    logic              core_run;
    logic              busy;
    logic              err;
    logic [31:0]       checksum;

    always #5 clk1 = ~clk1;

    risc_prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk1         (clk1),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .mem_we       (mem_we),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_halted  (core_halted),
        .core_start   (core_start),
        .core_pc_init (core_pc_init),
        .core_run     (core_run),
        .busy         (busy),
        .err          (err),
        .checksum     (checksum)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: loader phase plus expected outputs.
    // m_mode: 0 = waiting for header, 1 = payload, 2 = start pulse, 3 = core running
    bit          m_valid = 1'b0;
    int          m_mode, m_base, m_idx, m_n, m_a;
    bit          m_target;
    bit          e_we, e_sel, e_err;
    int          e_addr, e_pc;
    logic [31:0] e_wdata, e_cks;

    // Observation of DUT activity (writes captured into a shadow memory).
    logic [31:0] cap [0:1][0:1023];
    int          n_we = 0, n_start = 0, n_run = 0;
    logic [31:0] seen_pc;

    always @(negedge clk1) begin
        if (m_valid) begin
            check("in_ready", in_ready, m_mode <= 1);
            check("busy", busy, m_mode == 1);
            check("core_start", core_start, m_mode == 2);
            check("core_run", core_run, m_mode == 3);
            check("mem_we", mem_we, e_we);
            if (e_we) begin
                check("mem_sel", mem_sel, e_sel);
                check("mem_addr", mem_addr, e_addr);
                check("mem_wdata", mem_wdata, e_wdata);
            end
            if (m_mode == 2) check("core_pc_init", core_pc_init, e_pc);
            check("err", err, e_err);
            check("checksum", checksum, e_cks);
        end

        if (mem_we === 1'b1) begin
            cap[mem_sel][mem_addr] = mem_wdata;
            n_we++;
        end
        if (core_start === 1'b1) begin
            n_start++;
            seen_pc = 32'(core_pc_init);
        end
        if (core_run === 1'b1) n_run++;

        if (rst) begin
            m_valid = 1'b1;
            m_mode  = 0;
            e_we    = 1'b0;
            e_sel   = 1'b0;
            e_err   = 1'b0;
            e_cks   = '0;
            e_pc    = 0;
        end else if (m_valid) begin
            e_we = 1'b0;
            case (m_mode)
                0: if (in_valid) begin
                    if (in_data[29:26] != 4'd0 || in_data[15:10] != 6'd0) begin
                        e_err = 1'b1;
                    end else if (in_data[31]) begin
                        e_pc   = int'(in_data[9:0]);
                        m_mode = 2;
                    end else if (in_data[25:16] != 10'd0) begin
                        m_target = in_data[30];
                        m_base   = int'(in_data[9:0]);
                        m_n      = int'(in_data[25:16]);
                        m_idx    = 0;
                        m_mode   = 1;
                    end
                end
                1: if (in_valid) begin
                    m_a   = m_base + m_idx;
                    e_cks = e_cks ^ in_data;
                    if (m_a < (1 << ADDR_W)) begin
                        e_we    = 1'b1;
                        e_sel   = m_target;
                        e_addr  = m_a;
                        e_wdata = in_data;
                    end else begin
                        e_err = 1'b1;
                    end
                    m_idx++;
                    if (m_idx == m_n) m_mode = 0;
                end
                2: m_mode = 3;
                default: if (core_halted) m_mode = 0;
            endcase
        end
    end

    int max_gap   = 0;
    bit rand_halt = 1'b0;

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        int gap  = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        bit done = 1'b0;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            if (rand_halt) core_halted = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 50 && !done; k++) begin
            if (rand_halt) core_halted = 1'($urandom_range(0, 1));
            @(negedge clk1);
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: word %h not accepted within 50 cycles", d);
        end
    endtask

    task automatic run_go(input logic [31:0] hdr, input int run_cycles);
        rand_halt   = 1'b0;
        core_halted = 1'b0;
        send(hdr);
        repeat (run_cycles) tick();
        core_halted = 1'b1;
        tick();
        core_halted = 1'b0;
        tick();
    endtask

    logic [31:0] words [0:4];
    int          we0, st0, run0;
    int          kind, rn, rb;
    bit          rt;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; core_halted = 1'b0;
        tick(); tick();
        rst = 1'b0;

        check("rst_in_ready", in_ready, 1);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_sel", mem_sel, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_core_start", core_start, 0);
        check("rst_core_pc_init", core_pc_init, 0);
        check("rst_core_run", core_run, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_checksum", checksum, 0);

        // IMEM program, back-to-back beats
        we0 = n_we;
        send(32'h0004_0000);
        send(32'h4801_000a); send(32'h4802_0014); send(32'h6040_0800); send(32'hfc00_0000);
        tick(); tick();
        check("imem_writes", n_we - we0, 4);
        check("imem0", cap[0][0], 32'h4801_000a);
        check("imem3", cap[0][3], 32'hfc00_0000);
        check("imem_checksum", checksum, 32'h9c43_081e);

        // DMEM data with random gaps
        max_gap = 2;
        we0 = n_we;
        send(32'h4007_00C8);
        send(32'd10); send(32'd9); send(32'd7); send(32'd12); send(32'd30); send(32'd9); send(32'hffff_ffff);
        tick(); tick();
        check("dmem_writes", n_we - we0, 7);
        check("dmem200", cap[1][200], 32'd10);
        check("dmem204", cap[1][204], 32'd30);
        check("dmem206", cap[1][206], 32'hffff_ffff);
        check("dmem_checksum", checksum, 32'h63bc_f7fe);

        // Start the core at PC 5
        st0 = n_start; run0 = n_run;
        run_go(32'h8000_0005, 4);
        check("go_start_pulses", n_start - st0, 1);
        check("go_pc", seen_pc, 5);
        check("go_run_cycles", n_run - run0, 4);
        check("go_ready_after", in_ready, 1);

        // Reserved bit set: dropped, err raised
        we0 = n_we;
        send(32'h0401_0000);
        tick(); tick();
        check("rsvd_err", err, 1);
        check("rsvd_writes", n_we - we0, 0);
        check("rsvd_ready", in_ready, 1);

        // Overflow past the top of IMEM
        we0 = n_we;
        send(32'h0003_03FE);
        send(32'h1111_1111); send(32'h2222_2222); send(32'h3333_3333);
        tick(); tick();
        check("ovf_writes", n_we - we0, 2);
        check("ovf_3fe", cap[0][10'h3FE], 32'h1111_1111);
        check("ovf_3ff", cap[0][10'h3FF], 32'h2222_2222);
        check("ovf_ready", in_ready, 1);

        // Backpressure burst
        max_gap = 3;
        rand_halt = 1'b1;
        for (int i = 0; i < 5; i++) words[i] = $urandom;
        send(32'h0005_0010);
        for (int i = 0; i < 5; i++) send(words[i]);
        tick(); tick();
        for (int i = 0; i < 5; i++) check("bp_word", cap[0][16 + i], words[i]);

        // Reset mid-burst while a third beat is offered
        max_gap = 0;
        we0 = n_we;
        send(32'h0005_0020);
        send(32'haaaa_0001); send(32'haaaa_0002);
        rst = 1'b1; in_valid = 1'b1; in_data = 32'haaaa_0003;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        tick(); tick(); tick();
        check("rstmid_writes", n_we - we0, 2);
        check("rstmid_busy", busy, 0);
        check("rstmid_ready", in_ready, 1);
        check("rstmid_err", err, 0);
        check("rstmid_checksum", checksum, 0);

        // Randomized mix of bursts, odd headers and core runs
        for (int it = 0; it < 40; it++) begin
            kind    = $urandom_range(0, 19);
            max_gap = $urandom_range(0, 3);
            rt      = 1'($urandom_range(0, 1));
            rb      = $urandom_range(0, 1023);
            if (kind < 13) begin
                rn = $urandom_range(1, 6);
                if (kind < 3) rb = $urandom_range(1018, 1023);
                rand_halt = 1'b1;
                send({1'b0, rt, 4'b0, 10'(rn), 6'b0, 10'(rb)});
                for (int i = 0; i < rn; i++) send($urandom);
            end else if (kind < 15) begin
                rand_halt = 1'b1;
                send($urandom | ((kind == 13) ? 32'h0400_0000 : 32'h0000_1000));
            end else if (kind == 15) begin
                send({2'b00, 4'b0, 10'd0, 6'b0, 10'(rb)});
            end else begin
                run_go({1'b1, rt, 4'b0, 10'($urandom_range(0, 1023)), 6'b0, 10'(rb)},
                       $urandom_range(1, 5));
            end
        end
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_risc_prog_loader
`default_nettype wire
